// File: rtl/piso_pkg.sv
// Shared types and defaults for the piso_2 serial transmitter.
package piso_pkg;
    typedef enum logic {IDLE, SHIFT} piso_state_t;
    localparam int PISO_WIDTH_DFLT = 16;
endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter for piso_2: counts 0..FRAME_LEN-1 and flags the final bit.
module piso_bit_cnt #(
    parameter int FRAME_LEN = 16,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          at_last
);
    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

    assign at_last = (cnt == CW'(FRAME_LEN - 1));
endmodule

// File: rtl/piso_2.sv
// 16-bit PISO transmitter, MSB first, valid/ready load, sout_last on final frame bit.
// Define PISO_PARITY_EN to append an even-parity bit after the data LSB.
module piso_2
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pin,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    piso_state_t           state, state_nxt;
    logic [FRAME_LEN-1:0]  shift_reg, frame;
    logic [CNT_W-1:0]      bit_cnt_unused;
    logic                  at_last, cnt_clr, cnt_en, load_fire;

`ifdef PISO_PARITY_EN
    assign frame = {pin, ^pin};
`else
    assign frame = pin;
`endif

    piso_bit_cnt #(.FRAME_LEN(FRAME_LEN), .CW(CNT_W)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .cnt     (bit_cnt_unused),
        .at_last (at_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load_ready = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    // Last bit: either chain the next word or drop back to idle.
                    load_ready = 1'b1;
                    cnt_clr    = 1'b1;
                    state_nxt  = load_valid ? SHIFT : IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_fire = load_valid & load_ready;

    // sout is the registered head of the frame; shift_reg holds the bits still to go.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg <= '0;
            sout      <= 1'b0;
        end else if (load_fire) begin
            sout      <= frame[FRAME_LEN-1];
            shift_reg <= {frame[FRAME_LEN-2:0], 1'b0};
        end else if (state == SHIFT && !at_last) begin
            sout      <= shift_reg[FRAME_LEN-1];
            shift_reg <= {shift_reg[FRAME_LEN-2:0], 1'b0};
        end else if (state == SHIFT) begin
            sout      <= 1'b0;
            shift_reg <= '0;
        end
    end

    assign busy       = (state == SHIFT);
    assign sout_valid = busy;
    assign sout_last  = busy & at_last;
endmodule

// File: tb/tb_piso_2.sv
// Directed self-checking bench for piso_2: table of single frames plus multi-cycle corner sequences.
module tb_piso_2;
    localparam int W = 16;
`ifdef PISO_PARITY_EN
    localparam int FL  = W + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int FL  = W;
    localparam bit PAR = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] word;
        logic         par;   // hand-computed even parity of word
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pin;
    logic         load_valid;
    logic         load_ready, sout, sout_valid, sout_last, busy;
    logic [W-1:0] sipo;

    int n_chk  = 0;
    int n_pass = 0;

    piso_2 #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin        (pin),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Receiving SIPO: shifts in data bits only (parity bit excluded).
    always_ff @(posedge clk) begin
        if (!rst_n)
            sipo <= '0;
        else if (sout_valid && !(PAR && sout_last))
            sipo <= {sipo[W-2:0], sout};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [W-1:0] w, input logic p, input int i);
        if (i < W) return w[W-1-i];
        return p;
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, ".sout"},  32'(sout), 0);
        chk({nm, ".valid"}, 32'(sout_valid), 0);
        chk({nm, ".last"},  32'(sout_last), 0);
        chk({nm, ".busy"},  32'(busy), 0);
    endtask

    task automatic chk_bit(input string nm, input logic [W-1:0] w, input logic p, input int i);
        chk($sformatf("%s.sout[%0d]", nm, i), 32'(sout), 32'(exp_bit(w, p, i)));
        chk($sformatf("%s.valid[%0d]", nm, i), 32'(sout_valid), 1);
        chk($sformatf("%s.last[%0d]", nm, i), 32'(sout_last), 32'(i == FL - 1));
    endtask

    // Load one word from idle and check its whole frame, then the return to idle.
    task automatic send_frame(input string nm, input logic [W-1:0] w, input logic p);
        pin = w; load_valid = 1'b1;
        #1 chk({nm, ".ready_idle"}, 32'(load_ready), 1);
        step();
        load_valid = 1'b0;
        pin = W'($urandom);
        for (int i = 0; i < FL; i++) begin
            #1;
            chk_bit(nm, w, p, i);
            if (i < FL - 1) chk($sformatf("%s.ready[%0d]", nm, i), 32'(load_ready), 0);
            step();
        end
        chk_idle({nm, ".end"});
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'hA5C3, 1'b0};
        vecs[1] = '{16'hBEEF, 1'b1};
        vecs[2] = '{16'h8001, 1'b0};
        vecs[3] = '{16'h0001, 1'b1};
        vecs[4] = '{16'h0003, 1'b0};
        vecs[5] = '{16'h1234, 1'b1};

        // Reset asserted together with a load request: reset wins.
        rst_n = 1'b0; load_valid = 1'b1; pin = 16'hFFFF;
        step(); step();
        chk_idle("reset");
        rst_n = 1'b1; load_valid = 1'b0;
        step();
        chk_idle("post_reset");

        foreach (vecs[k])
            send_frame($sformatf("vec%0d", k), vecs[k].word, vecs[k].par);

        // Loopback into the SIPO model.
        send_frame("loop", 16'hBEEF, 1'b1);
        chk("loop.sipo", 32'(sipo), 32'h0000BEEF);

        // Back-to-back: second word taken in the last-bit cycle, no gap.
        pin = 16'hFFFF; load_valid = 1'b1;
        step();
        pin = 16'h0000;
        for (int i = 0; i < FL; i++) begin
            #1;
            chk_bit("b2b_a", 16'hFFFF, 1'b0, i);
            if (i == FL - 1) chk("b2b.ready_last", 32'(load_ready), 1);
            step();
        end
        load_valid = 1'b0;
        pin = 16'hFFFF;
        for (int i = 0; i < FL; i++) begin
            #1;
            chk_bit("b2b_b", 16'h0000, 1'b0, i);
            step();
        end
        chk_idle("b2b.end");

        // Load request mid-frame is ignored.
        pin = 16'h8001; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            #1;
            chk_bit("busy_ign", 16'h8001, 1'b0, i);
            if (i == 5) begin
                pin = 16'h7FFE; load_valid = 1'b1;
                #1 chk("busy_ign.ready", 32'(load_ready), 0);
            end else begin
                load_valid = 1'b0;
            end
            step();
        end
        chk_idle("busy_ign.end");
        step();
        chk_idle("busy_ign.no_2nd");

        // Reset mid-frame drops the frame; a fresh load then transmits cleanly.
        pin = 16'hF0F0; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk_bit("rst_mid", 16'hF0F0, 1'b0, i);
            step();
        end
        rst_n = 1'b0;
        step();
        chk_idle("rst_mid.flush");
        rst_n = 1'b1;
        send_frame("rst_mid.fresh", 16'h1234, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
